// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver / host logic and the receive FIFO.
// The master side drives receiver strobes and pop/clear requests; the slave
// side (the FIFO) drives the head byte, occupancy and error status.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rx_rdy;
    logic          rx_ferr;
    logic [7:0]    rx_data;
    logic          rd_en;
    logic          clr_err;
    logic [7:0]    dout;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overrun;
    logic [7:0]    ferr_cnt;

    modport master (
        output rx_rdy, rx_ferr, rx_data, rd_en, clr_err,
        input  dout, empty, full, count, overrun, ferr_cnt
    );

    modport slave (
        input  rx_rdy, rx_ferr, rx_data, rd_en, clr_err,
        output dout, empty, full, count, overrun, ferr_cnt
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer behind the UART receiver. Good bytes are
// queued, framing-error bytes are discarded and counted (saturating), and good
// bytes arriving while full are dropped and flagged by a sticky overrun bit.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input logic           clk,
    input logic           reset,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    ferr_cnt_q, ferr_cnt_d;
    logic          rdy_q;

    logic rx_evt;
    logic pop;
    logic slot_free;
    logic wr;
    logic ovr_evt;
    logic ferr_evt;

    // Rising edge of rx_rdy: a held level yields a single event, with no added latency.
    assign rx_evt    = bus.rx_rdy & ~rdy_q;
    assign pop       = bus.rd_en & ~empty_q;
    // A full FIFO still has room when the head byte leaves in the same cycle.
    assign slot_free = (count_q != CW'(DEPTH)) | pop;
    assign wr        = rx_evt & ~bus.rx_ferr & slot_free;
    assign ovr_evt   = rx_evt & ~bus.rx_ferr & ~slot_free;
    assign ferr_evt  = rx_evt & bus.rx_ferr;

    // Next-state for pointers, occupancy and error status.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        ferr_cnt_d = ferr_cnt_q;

        if (wr)  wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

        if (wr && !pop)      count_d = count_q + CW'(1);
        else if (pop && !wr) count_d = count_q - CW'(1);

        // Clear first, then let a same-cycle event override it.
        if (bus.clr_err) begin
            overrun_d  = 1'b0;
            ferr_cnt_d = 8'h00;
        end
        if (ovr_evt) overrun_d = 1'b1;
        if (ferr_evt && (ferr_cnt_d != 8'hFF)) ferr_cnt_d = ferr_cnt_d + 8'd1;

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_cnt_q <= 8'h00;
            rdy_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overrun_q  <= overrun_d;
            ferr_cnt_q <= ferr_cnt_d;
            rdy_q      <= bus.rx_rdy;
        end
    end

    // Byte storage written on accepted receives.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the empty flag masks stale contents.
        if (wr) mem_q[wr_ptr_q] <= bus.rx_data;
    end

    assign bus.dout     = empty_q ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.overrun  = overrun_q;
    assign bus.ferr_cnt = ferr_cnt_q;
endmodule
